// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the memory-side cache/RAM path.
// RAM status codes, arbiter states and the machine word.
package cpu_types_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of dcache grants taken
// while the icache is waiting; sat_o forces the next icache grant.
module arb_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int W     = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic upd_i,
  input  logic inc_i,
  output logic sat_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == W'(LIMIT));

  // next count: only moves on an IDLE grant decision
  always_comb begin
    cnt_d = cnt_q;
    if (upd_i) begin
      if (!inc_i)     cnt_d = '0;
      else if (sat_o) cnt_d = cnt_q;
      else            cnt_d = cnt_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache reads and dcache reads/writes
// onto one RAM port; dcache first, icache forced after a streak.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              bus_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state_q, state_d;
  logic [WORD_W-1:0] ramaddr_q, ramaddr_d;
  logic [WORD_W-1:0] ramstore_q, ramstore_d;
  logic              starved;
  logic              upd;
  logic              inc;
  logic              own_req;
  ramstate_t         rs;

  assign rs       = ramstate_t'(ramstate);
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;

  // a dcache grant while icache waits grows the streak
  assign upd = (state_q == IDLE);
  assign inc = iREN && !starved && (dWEN || dREN);

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .W     (SW)
  ) u_starve (
    .clk_i (CLK),
    .rst_i (RST),
    .upd_i (upd),
    .inc_i (inc),
    .sat_o (starved)
  );

  // grant selection, RAM strobes and completion handshake
  always_comb begin
    state_d    = state_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    bus_err    = 1'b0;
    own_req    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iREN && starved) begin
          state_d   = I_RD;
          ramaddr_d = iaddr;
        end else if (dWEN) begin
          state_d    = D_WR;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
        end else if (dREN) begin
          state_d   = D_RD;
          ramaddr_d = daddr;
        end else if (iREN) begin
          state_d   = I_RD;
          ramaddr_d = iaddr;
        end
      end
      I_RD: begin
        ramREN  = 1'b1;
        own_req = iREN;
      end
      D_RD: begin
        ramREN  = 1'b1;
        own_req = dREN;
      end
      D_WR: begin
        ramWEN  = 1'b1;
        own_req = dWEN;
      end
      default: ;
    endcase
    if (state_q != IDLE) begin
      if (rs == ERROR) bus_err = 1'b1;
      // a dropped request never sees its wait released
      if (!own_req || rs == ERROR) begin
        state_d = IDLE;
      end else if (rs == ACCESS) begin
        state_d = IDLE;
        unique case (state_q)
          I_RD: begin
            iwait = 1'b0;
            iload = ramload;
          end
          D_RD: begin
            dwait = 1'b0;
            dload = ramload;
          end
          D_WR: dwait = 1'b0;
          default: ;
        endcase
      end
    end
  end

  // state, captured address and write data
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
    end else begin
      state_q    <= state_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
    end
  end

endmodule
